expr_string_tx: RTL and testbench

//  Serializes a packed expression (BCD operands + operator codes) into an ASCII stream "d op d op ... d".
//  One character per transfer over a valid/ready handshake.

---
 rtl/expr_string_tx_if.sv | 31 +++
 rtl/expr_string_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_expr_string_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/expr_string_tx_if.sv
// -----------------------------------------------------------------------------
// expr_string_tx_if
// Character stream carrying one ASCII character per valid/ready transfer.
//   out_valid : source has a character on out_char
//   out_ready : sink accepts the character this cycle
//   out_char  : ASCII character
//   out_last  : character is the final one of the expression
// Modports:
//   master : the character source (drives valid/char/last, reads ready)
//   slave  : the character sink   (reads valid/char/last, drives ready)
// -----------------------------------------------------------------------------
interface expr_string_tx_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_last;

    modport master (
        output out_valid,
        output out_char,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_char,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/expr_string_tx.sv
// -----------------------------------------------------------------------------
// expr_string_tx
// Serializes a packed expression (BCD operands plus 2-bit operator codes) into
// the ASCII stream "d op d op ... d", one character per transfer. Every complete
// stream is a string the expression recognizer accepts.
//
// Parameters:
//   MAX_OPS : maximum operand count per expression
//   LEN_W   : width of len (2**LEN_W > MAX_OPS)
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-high reset
//   start  : request, only looked at in IDLE
//   len    : operand count, legal 1..MAX_OPS
//   digits : BCD operand i at [4i+3:4i]
//   ops    : operator i at [2i+1:2i]; 00 '+', 01 '-', 10 '*', 11 '/'
//   busy   : high while a stream is in progress (DIGIT/OP/DONE)
//   done   : one-cycle pulse after the final character was transferred
//   err    : one-cycle pulse after a rejected request
//   tx     : character stream (master side)
// All outputs come straight from flops; nothing combinational reaches them
// from an input.
// -----------------------------------------------------------------------------
module expr_string_tx #(
    parameter int MAX_OPS = 4,
    parameter int LEN_W   = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic [4*MAX_OPS-1:0]   digits,
    input  logic [2*MAX_OPS-3:0]   ops,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    expr_string_tx_if.master       tx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_OP    = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Request is legal when the operand count is in range and every used
    // operand is a BCD digit; operands at index >= len are ignored.
    function automatic logic req_legal(input logic [LEN_W-1:0] l,
                                       input logic [4*MAX_OPS-1:0] d);
        logic ok;
        ok = (l != {LEN_W{1'b0}}) && (l <= LEN_W'(MAX_OPS));
        for (int i = 0; i < MAX_OPS; i++) begin
            ok = ok & ~((LEN_W'(i) < l) && (d[4*i +: 4] > 4'd9));
        end
        return ok;
    endfunction

    // ASCII code of a BCD digit.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // ASCII code of an operator code.
    function automatic logic [7:0] op_char(input logic [1:0] o);
        logic [7:0] c;
        case (o)
            2'b00:   c = 8'h2B;
            2'b01:   c = 8'h2D;
            2'b10:   c = 8'h2A;
            2'b11:   c = 8'h2F;
            default: c = 8'h2B;
        endcase
        return c;
    endfunction

    state_t               state_r, state_s;
    logic [LEN_W-1:0]     idx_r, idx_s;
    logic [LEN_W-1:0]     len_r, len_s;
    logic [4*MAX_OPS-1:0] digits_r, digits_s;
    // Operators are stored padded by one slot so the operator select below
    // never leaves the vector, even for idx = MAX_OPS-1.
    logic [2*MAX_OPS-1:0] ops_r, ops_s;
    logic                 err_s;
    logic                 valid_s;
    logic                 last_s;
    logic [7:0]           char_s;
    logic                 xfer_s;

    logic                 out_valid_r;
    logic                 out_last_r;
    logic [7:0]           out_char_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    assign xfer_s       = out_valid_r & tx.out_ready;
    assign tx.out_valid = out_valid_r;
    assign tx.out_char  = out_char_r;
    assign tx.out_last  = out_last_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

    // Next-state logic: request acceptance, character advance, done/idle return.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        len_s    = len_r;
        digits_s = digits_r;
        ops_s    = ops_r;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (req_legal(len, digits)) begin
                        state_s  = ST_DIGIT;
                        idx_s    = {LEN_W{1'b0}};
                        len_s    = len;
                        digits_s = digits;
                        ops_s    = {2'b00, ops};
                    end else begin
                        err_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIGIT: begin
                if (xfer_s) begin
                    if (idx_r == len_r - LEN_W'(1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_OP;
                    end
                end else begin
                    state_s = ST_DIGIT;
                end
            end
            ST_OP: begin
                if (xfer_s) begin
                    idx_s   = idx_r + LEN_W'(1);
                    state_s = ST_DIGIT;
                end else begin
                    state_s = ST_OP;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with
    // the state they describe; a stalled transfer keeps state/idx and therefore
    // keeps the character stable.
    always_comb begin
        valid_s = 1'b0;
        last_s  = 1'b0;
        char_s  = 8'h00;
        case (state_s)
            ST_DIGIT: begin
                valid_s = 1'b1;
                char_s  = digit_char(digits_s[{idx_s, 2'b00} +: 4]);
                last_s  = (idx_s == len_s - LEN_W'(1));
            end
            ST_OP: begin
                valid_s = 1'b1;
                char_s  = op_char(ops_s[{idx_s, 1'b0} +: 2]);
                last_s  = 1'b0;
            end
            default: begin
                valid_s = 1'b0;
                last_s  = 1'b0;
                char_s  = 8'h00;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            idx_r    <= {LEN_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            digits_r <= {(4*MAX_OPS){1'b0}};
            ops_r    <= {(2*MAX_OPS){1'b0}};
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            len_r    <= len_s;
            digits_r <= digits_s;
            ops_r    <= ops_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_char_r  <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            out_valid_r <= valid_s;
            out_last_r  <= last_s;
            out_char_r  <= char_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
            err_r       <= err_s;
        end
    end

endmodule

// File: tb/tb_expr_string_tx.sv
// -----------------------------------------------------------------------------
// tb_expr_string_tx
// Directed scenarios plus randomized requests for expr_string_tx. Expected
// character strings, legality and cycle timing come from a plain model of the
// expression format; received characters are collected at every rising edge.
// -----------------------------------------------------------------------------
module tb_expr_string_tx;
    localparam int MAX_OPS = 4;
    localparam int LEN_W   = 3;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  len;
    logic [15:0] digits;
    logic [5:0]  ops;
    logic        busy;
    logic        done;
    logic        err;

    expr_string_tx_if tx_if ();

    expr_string_tx #(.MAX_OPS(MAX_OPS), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .len    (len),
        .digits (digits),
        .ops    (ops),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .tx     (tx_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Collector state, updated at each rising edge.
    int         cyc       = 0;
    logic [8:0] rx_q[$];
    int         rx_cyc[$];
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         done_cyc  = -1;
    int         err_cyc   = -1;
    int         start_cyc = -1;
    logic       mark      = 1'b0;
    logic       held      = 1'b0;
    logic [8:0] held_v    = 9'h000;

    // Records transfers/pulses and checks that a stalled character holds.
    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            held = 1'b0;
        end else begin
            if (mark) start_cyc = cyc;
            if (held) check("hold", 32'({tx_if.out_valid, tx_if.out_last, tx_if.out_char}),
                            32'({1'b1, held_v}));
            held   = tx_if.out_valid && !tx_if.out_ready;
            held_v = {tx_if.out_last, tx_if.out_char};
            if (tx_if.out_valid && tx_if.out_ready) begin
                rx_q.push_back({tx_if.out_last, tx_if.out_char});
                rx_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err)  begin err_cnt++;  err_cyc  = cyc; end
        end
    end

    function automatic logic ready_bit(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 3) == 0);
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    // Expression recognizer: digit, then alternating operator/digit, ending on a digit.
    function automatic bit recog(input logic [8:0] q[$]);
        bit want_digit = 1'b1;
        bit bad = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            logic [7:0] c;
            c = q[i][7:0];
            if (want_digit && c >= 8'h30 && c <= 8'h39) want_digit = 1'b0;
            else if (!want_digit && (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F))
                want_digit = 1'b1;
            else bad = 1'b1;
        end
        return !bad && !want_digit && (q.size() > 0);
    endfunction

    // One request: inj 0 = none, 1 = random start pulses while busy, 2 = start held while busy.
    task automatic run_req(input logic [2:0] l, input logic [15:0] d, input logic [5:0] o,
                           input int mode, input int inj, input string tag);
        int         dc0 = done_cnt;
        int         ec0 = err_cnt;
        bit         legal;
        bit         fin = 1'b0;
        logic [8:0] exp_q[$];
        string      op_tab = "+-*/";
        legal = (l >= 3'd1) && (int'(l) <= MAX_OPS);
        for (int i = 0; i < int'(l) && i < MAX_OPS; i++)
            if (d[4*i +: 4] > 4'd9) legal = 1'b0;
        if (legal) begin
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back({(i == int'(l) - 1), 8'h30 + {4'h0, d[4*i +: 4]}});
                if (i < int'(l) - 1) exp_q.push_back({1'b0, op_tab[int'(o[2*i +: 2])]});
            end
        end
        rx_q.delete();
        rx_cyc.delete();
        tx_if.out_ready = ready_bit(mode, 0);
        len = l; digits = d; ops = o;
        start = 1'b1; mark = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk); #1;
            start = 1'b0; mark = 1'b0;
            tx_if.out_ready = ready_bit(mode, c + 1);
            if (done_cnt != dc0 || err_cnt != ec0) fin = 1'b1;
            else if (busy && (inj == 2 || (inj == 1 && $urandom_range(0, 3) == 0))) begin
                start  = 1'b1;
                len    = 3'($urandom_range(1, 4));
                digits = 16'($urandom);
                ops    = 6'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'(1));
        if (legal) begin
            check({tag, "_count"}, 32'(rx_q.size()), 32'(2 * int'(l) - 1));
            for (int i = 0; i < exp_q.size(); i++)
                if (i < rx_q.size()) check({tag, "_char"}, 32'(rx_q[i]), 32'(exp_q[i]));
            check({tag, "_done"}, 32'(done_cnt - dc0), 32'(1));
            check({tag, "_noerr"}, 32'(err_cnt - ec0), 32'(0));
            check({tag, "_recog"}, 32'(recog(rx_q)), 32'(1));
            if (mode == 0 && inj == 0 && rx_cyc.size() > 0) begin
                check({tag, "_first_cyc"}, 32'(rx_cyc[0] - start_cyc), 32'(1));
                check({tag, "_last_cyc"}, 32'(rx_cyc[rx_cyc.size() - 1] - start_cyc),
                      32'(2 * int'(l) - 1));
                check({tag, "_done_cyc"}, 32'(done_cyc - start_cyc), 32'(2 * int'(l)));
            end
        end else begin
            check({tag, "_err"}, 32'(err_cnt - ec0), 32'(1));
            check({tag, "_nodone"}, 32'(done_cnt - dc0), 32'(0));
            check({tag, "_nochars"}, 32'(rx_q.size()), 32'(0));
            if (inj == 0) check({tag, "_err_cyc"}, 32'(err_cyc - start_cyc), 32'(1));
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; len = 3'd0; digits = 16'h0000; ops = 6'b000000;
        tx_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({tx_if.out_valid, tx_if.out_char, tx_if.out_last, busy, done, err}),
              32'(0));
        clr = 1'b0;
        @(posedge clk); #1;

        run_req(3'd3, 16'h0321, 6'b00_10_00, 0, 0, "t1");
        run_req(3'd1, 16'h0007, 6'b000000, 0, 0, "t2");
        run_req(3'd3, 16'h0321, 6'b00_10_00, 1, 0, "t3");
        run_req(3'd2, 16'h00A4, 6'b000000, 0, 0, "t4_bad_digit");
        run_req(3'd0, 16'h0001, 6'b000000, 0, 0, "t4_len0");
        run_req(3'd5, 16'h1234, 6'b000000, 0, 0, "t4_len5");
        run_req(3'd4, 16'h9876, 6'b11_01_10, 0, 0, "t4_after");

        // Reset in the middle of a stream.
        rx_q.delete(); rx_cyc.delete();
        tx_if.out_ready = 1'b1;
        len = 3'd3; digits = 16'h0321; ops = 6'b00_10_00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && rx_q.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        #1;
        check("t5_clr_outputs", 32'({tx_if.out_valid, tx_if.out_char, tx_if.out_last, busy, done, err}),
              32'(0));
        check("t5_pre_count", 32'(rx_q.size()), 32'(2));
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        run_req(3'd2, 16'h0090, 6'b000001, 0, 0, "t5");

        // start held during the whole stream must not disturb it.
        run_req(3'd3, 16'h0321, 6'b00_10_00, 0, 2, "t6");
        run_req(3'd4, 16'h0458, 6'b01_11_00, 2, 2, "t6b");

        for (int n = 0; n < 60; n++) begin
            logic [15:0] d;
            for (int i = 0; i < 4; i++)
                d[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            run_req(3'($urandom_range(0, 6)), d, 6'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 1), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
